// File: rtl/rollover_divider.sv
// Divides the 15->0 wraps of an upstream counter by a programmable ratio and flags illegal count steps.
// Define ROLLOVER_DIV_SQWAVE_EN to build the divided square-wave output; otherwise div_clk_o is tied low.
module rollover_divider #(
    parameter int CNT_W = 4,
    parameter int DIV_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic [DIV_W-1:0] ratio_i,
    input  logic             ratio_vld_i,
    output logic             ratio_rdy_o,
    output logic             tick_o,
    output logic             div_clk_o,
    output logic             seq_err_o,
    input  logic             clr_err_i,
    output logic [1:0]       state_dbg_o
);

    // Ratio handshake: a ratio transfers on every rising edge where ratio_vld_i && ratio_rdy_o.
    // Ready depends only on state (low in PEND); the producer holds ratio_i stable while valid is high.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_PEND = 2'b10
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_prev_q;
    logic [CNT_W-1:0] w_prev_inc;
    logic             r_prev_vld;
    logic [DIV_W-1:0] r_ev_cnt;
    logic [DIV_W-1:0] w_ev_cnt_nxt;
    logic [DIV_W-1:0] r_act_ratio;
    logic [DIV_W-1:0] w_act_nxt;
    logic [DIV_W-1:0] r_pend_ratio;
    logic [DIV_W-1:0] w_pend_nxt;
    logic [DIV_W-1:0] w_last_idx;
    logic             r_tick;
    logic             w_tick_nxt;
    logic             r_seq_err;
    logic             w_rollover;
    logic             w_seq_bad;
    logic             w_hs;
    logic             w_run_en;
    logic             w_terminal;

    assign w_prev_inc = r_prev_q + CNT_W'(1);
    assign w_rollover = r_prev_vld && (r_prev_q == {CNT_W{1'b1}}) && (cnt_i == '0);
    assign w_seq_bad  = r_prev_vld && (cnt_i != r_prev_q) && (cnt_i != w_prev_inc);
    assign w_hs       = ratio_vld_i && ratio_rdy_o;
    assign w_run_en   = en_i && ((r_state == ST_RUN) || (r_state == ST_PEND));

    // Ratios 0 and 1 both mean a tick on every rollover.
    assign w_last_idx = (r_act_ratio > DIV_W'(1)) ? (r_act_ratio - DIV_W'(1)) : '0;
    assign w_terminal = w_rollover && (r_ev_cnt == w_last_idx);

    assign ratio_rdy_o = (r_state != ST_PEND);
    assign tick_o      = r_tick;
    assign seq_err_o   = r_seq_err;
    assign state_dbg_o = r_state;

    always_comb begin
        w_state_nxt  = r_state;
        w_ev_cnt_nxt = r_ev_cnt;
        w_act_nxt    = r_act_ratio;
        w_pend_nxt   = r_pend_ratio;
        w_tick_nxt   = 1'b0;

        if (w_run_en && w_rollover) begin
            if (w_terminal) begin
                w_tick_nxt   = 1'b1;
                w_ev_cnt_nxt = '0;
            end else begin
                w_ev_cnt_nxt = r_ev_cnt + DIV_W'(1);
            end
        end

        case (r_state)
            ST_IDLE: begin
                w_ev_cnt_nxt = '0;
                if (w_hs) begin
                    w_act_nxt = ratio_i;
                end
                if (en_i) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!en_i) begin
                    // Disable wins over any rollover; a ratio accepted on this edge applies directly.
                    w_state_nxt  = ST_IDLE;
                    w_ev_cnt_nxt = '0;
                    if (w_hs) begin
                        w_act_nxt = ratio_i;
                    end
                end else if (w_hs) begin
                    w_pend_nxt  = ratio_i;
                    w_state_nxt = ST_PEND;
                end
            end
            ST_PEND: begin
                if (!en_i) begin
                    w_state_nxt  = ST_IDLE;
                    w_ev_cnt_nxt = '0;
                    w_act_nxt    = r_pend_ratio;
                end else if (w_terminal) begin
                    // New ratio starts with the period after this tick; the running period is never cut short.
                    w_act_nxt   = r_pend_ratio;
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_ev_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_prev_q     <= '0;
            r_prev_vld   <= 1'b0;
            r_ev_cnt     <= '0;
            r_act_ratio  <= DIV_W'(1);
            r_pend_ratio <= '0;
            r_tick       <= 1'b0;
            r_seq_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_prev_q     <= cnt_i;
            r_prev_vld   <= 1'b1;
            r_ev_cnt     <= w_ev_cnt_nxt;
            r_act_ratio  <= w_act_nxt;
            r_pend_ratio <= w_pend_nxt;
            r_tick       <= w_tick_nxt;
            // Sticky error: a new bad step outranks a clear in the same cycle.
            if (w_seq_bad) begin
                r_seq_err <= 1'b1;
            end else if (clr_err_i) begin
                r_seq_err <= 1'b0;
            end
        end
    end

`ifdef ROLLOVER_DIV_SQWAVE_EN
    logic r_div_clk;
    logic w_div_clk_nxt;

    always_comb begin
        w_div_clk_nxt = r_div_clk;
        if (!w_run_en) begin
            w_div_clk_nxt = 1'b0;
        end else if (w_terminal) begin
            w_div_clk_nxt = ~r_div_clk;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_div_clk <= 1'b0;
        end else begin
            r_div_clk <= w_div_clk_nxt;
        end
    end

    assign div_clk_o = r_div_clk;
`else
    assign div_clk_o = 1'b0;
`endif

endmodule

// File: tb/tb_rollover_divider.sv
// Directed bench for rollover_divider: expected tick cycles are queued as stimulus is planned
// and compared every cycle; div_clk_o is checked against the bench's own toggle model.
module tb_rollover_divider;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_PEND = 2'b10;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       en_i = 1'b0;
    logic [3:0] cnt_i = 4'd0;
    logic [7:0] ratio_i = 8'd0;
    logic       ratio_vld_i = 1'b0;
    logic       ratio_rdy_o;
    logic       tick_o;
    logic       div_clk_o;
    logic       seq_err_o;
    logic       clr_err_i = 1'b0;
    logic [1:0] state_dbg_o;

    int          n_assert = 0;
    int          n_fail = 0;
    logic [31:0] cyc = 32'd0;
    logic [31:0] base = 32'd0;
    logic [3:0]  base_cnt = 4'd0;
    logic        run_cnt = 1'b0;
    logic        exp_div = 1'b0;
    logic [31:0] exp_q[$];

    always #5 clk_i = ~clk_i;

    rollover_divider #(.CNT_W(4), .DIV_W(8)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .en_i       (en_i),
        .cnt_i      (cnt_i),
        .ratio_i    (ratio_i),
        .ratio_vld_i(ratio_vld_i),
        .ratio_rdy_o(ratio_rdy_o),
        .tick_o     (tick_o),
        .div_clk_o  (div_clk_o),
        .seq_err_o  (seq_err_o),
        .clr_err_i  (clr_err_i),
        .state_dbg_o(state_dbg_o)
    );

    // Cycle at which the m-th 15->0 wrap after 'base' shows its tick, counter free-running from base_cnt.
    function automatic logic [31:0] wrap_cyc(input int m);
        return base + 32'd16 - 32'(base_cnt) + 32'(16 * (m - 1)) + 32'd1;
    endfunction

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s @cyc %0d: observed %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    task automatic check2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s @cyc %0d: observed %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: sample #1 after the edge, score tick/div_clk, then drive the next count.
    task automatic cycle();
        logic exp_tick;
        @(posedge clk_i);
        #1;
        cyc = cyc + 32'd1;
        exp_tick = 1'b0;
        if (exp_q.size() > 0 && exp_q[0] == cyc) begin
            exp_tick = 1'b1;
            void'(exp_q.pop_front());
        end
`ifdef ROLLOVER_DIV_SQWAVE_EN
        if (exp_tick) exp_div = ~exp_div;
`endif
        check1("tick", tick_o, exp_tick);
        check1("div_clk", div_clk_o, exp_div);
        if (run_cnt) cnt_i = cnt_i + 4'd1;
    endtask

    task automatic run_until(input logic [31:0] t);
        while (cyc < t) cycle();
    endtask

    task automatic go_idle();
        run_cnt = 1'b0;
        en_i = 1'b0;
        exp_div = 1'b0;
        cycle();
        check2("idle_state", state_dbg_o, ST_IDLE);
        check1("idle_rdy", ratio_rdy_o, 1'b1);
    endtask

    task automatic load_and_start(input logic [7:0] r);
        ratio_i = r;
        ratio_vld_i = 1'b1;
        check1("load_rdy", ratio_rdy_o, 1'b1);
        cycle();
        ratio_vld_i = 1'b0;
        en_i = 1'b1;
        cycle();
        check2("run_state", state_dbg_o, ST_RUN);
        base = cyc;
        base_cnt = cnt_i;
        run_cnt = 1'b1;
    endtask

    initial begin
        // Reset values
        repeat (2) @(posedge clk_i);
        #1;
        check1("rst_tick", tick_o, 1'b0);
        check1("rst_div", div_clk_o, 1'b0);
        check1("rst_err", seq_err_o, 1'b0);
        check1("rst_rdy", ratio_rdy_o, 1'b1);
        check2("rst_state", state_dbg_o, ST_IDLE);
        rst_i = 1'b0;

        // Sequence error: 5 -> 9, hold, increment, set-wins-over-clear, clear alone
        for (int v = 1; v <= 5; v++) begin
            cnt_i = 4'(v);
            cycle();
        end
        check1("err_legal", seq_err_o, 1'b0);
        cnt_i = 4'd9;
        cycle();
        check1("err_set", seq_err_o, 1'b1);
        cycle();
        check1("err_hold9", seq_err_o, 1'b1);
        cnt_i = 4'd10;
        cycle();
        check1("err_inc10", seq_err_o, 1'b1);
        cnt_i = 4'd12;
        clr_err_i = 1'b1;
        cycle();
        check1("err_set_wins", seq_err_o, 1'b1);
        cycle();
        clr_err_i = 1'b0;
        check1("err_cleared", seq_err_o, 1'b0);
        run_cnt = 1'b1;
        repeat (4) cycle();
        run_cnt = 1'b0;
        check1("err_back_to_0", seq_err_o, 1'b0);

        // Basic division by 3
        load_and_start(8'd3);
        exp_q.push_back(wrap_cyc(3));
        exp_q.push_back(wrap_cyc(6));
        exp_q.push_back(wrap_cyc(9));
        run_until(wrap_cyc(9) + 32'd1);
        check1("div3_rdy", ratio_rdy_o, 1'b1);

        // Ratio 0 and ratio 1: a tick per rollover
        go_idle();
        load_and_start(8'd0);
        for (int m = 1; m <= 3; m++) exp_q.push_back(wrap_cyc(m));
        run_until(wrap_cyc(3) + 32'd1);
        go_idle();
        load_and_start(8'd1);
        for (int m = 1; m <= 3; m++) exp_q.push_back(wrap_cyc(m));
        run_until(wrap_cyc(3) + 32'd1);

        // Ratio change 4 -> 2 offered mid-period
        go_idle();
        load_and_start(8'd4);
        exp_q.push_back(wrap_cyc(4));
        exp_q.push_back(wrap_cyc(8));
        exp_q.push_back(wrap_cyc(10));
        exp_q.push_back(wrap_cyc(12));
        run_until(wrap_cyc(5) + 32'd3);
        ratio_i = 8'd2;
        ratio_vld_i = 1'b1;
        check1("chg_rdy_before", ratio_rdy_o, 1'b1);
        cycle();
        ratio_vld_i = 1'b0;
        check2("chg_pend_state", state_dbg_o, ST_PEND);
        check1("chg_rdy_low", ratio_rdy_o, 1'b0);
        cycle();
        ratio_i = 8'd7;
        ratio_vld_i = 1'b1;
        cycle();
        ratio_vld_i = 1'b0;
        check1("chg_rdy_still_low", ratio_rdy_o, 1'b0);
        run_until(wrap_cyc(8));
        check2("chg_back_run", state_dbg_o, ST_RUN);
        check1("chg_rdy_high", ratio_rdy_o, 1'b1);
        run_until(wrap_cyc(13) + 32'd2);

        // Drop enable on the edge of a terminal rollover: no tick, IDLE, div_clk low
        run_until(wrap_cyc(14) - 32'd1);
        en_i = 1'b0;
        exp_div = 1'b0;
        cycle();
        check2("dis_idle", state_dbg_o, ST_IDLE);
        repeat (20) cycle();
        run_cnt = 1'b0;

        // Asynchronous reset mid-period with tick high and error set
        cnt_i = cnt_i + 4'd2;
        cycle();
        check1("err_reset_pre", seq_err_o, 1'b1);
        load_and_start(8'd2);
        exp_q.push_back(wrap_cyc(2));
        run_until(wrap_cyc(2));
        check1("pre_rst_err", seq_err_o, 1'b1);
        #2;
        rst_i = 1'b1;
        #1;
        check1("arst_tick", tick_o, 1'b0);
        check1("arst_div", div_clk_o, 1'b0);
        check1("arst_err", seq_err_o, 1'b0);
        check1("arst_rdy", ratio_rdy_o, 1'b1);
        check2("arst_state", state_dbg_o, ST_IDLE);
        exp_div = 1'b0;
        run_cnt = 1'b0;
        en_i = 1'b0;
        cnt_i = 4'd9;
        #2;
        rst_i = 1'b0;
        cycle();
        check1("no_check_first_cycle", seq_err_o, 1'b0);
        cnt_i = 4'd10;
        cycle();
        check1("post_rst_legal", seq_err_o, 1'b0);
        check32("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
